// File: rtl/run_step_controller_pkg.sv
// Shared state encoding for the run/step front-panel controller.
// The encoding doubles as the externally visible mode value.
package rsc_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

endpackage

// File: rtl/run_step_controller_button_conditioner.sv
// Pushbutton conditioning: 2-flop synchronizer, debounce counter and
// rising-edge press detector producing a one-cycle evt per press.
module button_conditioner #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic evt
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any agreeing sample restarts the count, so only an unbroken run of
  // DB_CYCLES differing samples moves the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign evt   = level_q & ~level_prev_q;

endmodule

// File: rtl/run_step_controller.sv
// Front-panel run/step/halt sequencer driving the CPU clock-enable.
// Optional breakpoint stop support is compiled in with RSC_BREAKPOINT_EN.
module run_step_controller
  import rsc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_btn,
  input  logic               step_btn,
  input  logic               cycle_done,
  input  logic               cpu_halt,
`ifdef RSC_BREAKPOINT_EN
  input  logic               bp_hit,
  output logic               bp_stop,
`endif
  output logic               cpu_en,
  output logic [STATE_W-1:0] mode,
  output logic               run_evt,
  output logic               step_evt
);

  state_t state_q;
  state_t state_d;
  logic   run_level;
  logic   step_level;

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_run_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (run_btn),
    .level (run_level),
    .evt   (run_evt)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_step_cond (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (step_level),
    .evt   (step_evt)
  );

`ifdef RSC_BREAKPOINT_EN
  logic bp_stop_q;
  logic bp_stop_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef RSC_BREAKPOINT_EN
    bp_stop_d = bp_stop_q;
    if (run_evt || step_evt) begin
      bp_stop_d = 1'b0;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (run_evt) begin
          state_d = ST_RUN;
        end else if (step_evt) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_d = ST_HALTED;
`ifdef RSC_BREAKPOINT_EN
        end else if (bp_hit) begin
          state_d   = ST_IDLE;
          bp_stop_d = 1'b1;
`endif
        end else if (run_evt) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (cpu_halt) begin
          state_d = ST_HALTED;
        end else if (cycle_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef RSC_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_stop_q <= 1'b0;
    end else begin
      bp_stop_q <= bp_stop_d;
    end
  end

  assign bp_stop = bp_stop_q;
`endif

  assign mode   = state_q;
  assign cpu_en = (state_q == ST_RUN) || (state_q == ST_STEP);

  // Debounced levels are only consumed as press events.
  logic unused_levels;
  assign unused_levels = run_level ^ step_level;

endmodule
